// File: rtl/fifo_axis_reader_pkg.sv
// Shared types and constants for the FWFT FIFO to AXI4-Stream reader.
package fifo_axis_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry in-order buffer: head register drives the stream, skid register
// holds the second beat so the producer side never looks at tready.
module axis_skid_buf
    import fifo_axis_reader_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) head_d = push_data_i;
                else                 skid_d = push_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == FULL) head_d = skid_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous accept and fill keeps the occupancy unchanged.
                if (count_q == FULL) begin
                    head_d = skid_q;
                    skid_d = push_data_i;
                end else begin
                    head_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fifo_axis_reader.sv
// Pops an FWFT FIFO into an AXI4-Stream master, framing packets by a
// configured beat count.
//
// state    | meaning
// ST_IDLE  | waiting for a packet length on cfg_valid/cfg_ready
// ST_RUN   | popping FIFO words into the output buffer
// ST_DRAIN | all words popped, waiting for the tlast beat to be accepted
module fifo_axis_reader
    import fifo_axis_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  if_empty_n,
    output logic                  if_read_ce,
    output logic                  if_read,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  done,
    output logic                  busy
);

    state_t               state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] pop_cnt_q;
    logic                 done_q;

    logic [1:0]          buf_count;
    logic                buf_valid;
    logic [DATA_WIDTH:0] buf_head;
    logic                accept;
    logic                pop;
    logic                pop_last;

    // Pop decision uses only registered state, keeping tready off the FIFO path.
    assign pop      = (state_q == ST_RUN) && if_empty_n && (buf_count < 2'(BUF_DEPTH));
    assign pop_last = (pop_cnt_q == len_q - LEN_WIDTH'(1));
    assign accept   = buf_valid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            pop_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            len_q     <= cfg_len;
                            pop_cnt_q <= '0;
                            state_q   <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        pop_cnt_q <= pop_cnt_q + LEN_WIDTH'(1);
                        if (pop_last) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (accept && (buf_count == 2'd1)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    axis_skid_buf #(
        .W (DATA_WIDTH + 1)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (pop),
        .push_data_i ({pop_last, if_dout}),
        .pop_i       (accept),
        .valid_o     (buf_valid),
        .head_o      (buf_head),
        .count_o     (buf_count)
    );

    assign cfg_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign if_read       = pop;
    assign if_read_ce    = pop;
    assign m_axis_tvalid = buf_valid;
    assign m_axis_tdata  = buf_head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = buf_head[DATA_WIDTH];
    assign done          = done_q;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: queue-based FIFO and stream model checked every cycle.
module tb_fifo_axis_reader;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [LW-1:0] cfg_len = '0;
    logic          if_empty_n = 1'b0;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          done;
    logic          busy;

    always #5 clk = ~clk;

    fifo_axis_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_len       (cfg_len),
        .if_empty_n    (if_empty_n),
        .if_read_ce    (if_read_ce),
        .if_read       (if_read),
        .if_dout       (if_dout),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .done          (done),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO contents (stimulus-owned) and every word ever written, in order.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] stream_q[$];

    // Monitor-owned model state.
    int   outstanding = 0, pops_rem = 0, cur_len = 0, beat_idx = 0, acc_idx = 0;
    int   cyc = 0, pop_total = 0, done_total = 0;
    logic exp_done = 1'b0, prev_hold = 1'b0, prev_last = 1'b0, pop_flag = 1'b0;
    logic mon_en = 1'b0;
    logic acc, fire, exp_read, exp_last;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] log_data[$];
    logic          log_last[$];
    int            log_cyc[$];

    always @(negedge clk) begin
        cyc++;
        acc      = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b1);
        fire     = (cfg_valid === 1'b1) && (cfg_ready === 1'b1);
        pop_flag = (if_read === 1'b1);
        if (reset || !mon_en) begin
            outstanding = 0;
            pops_rem    = 0;
            beat_idx    = 0;
            exp_done    = 1'b0;
            prev_hold   = 1'b0;
            acc_idx     = stream_q.size();
        end else begin
            if (done === 1'b1) done_total++;
            if (if_read === 1'b1) pop_total++;
            exp_read = (pops_rem != 0) && (outstanding < 2) && if_empty_n;
            chk("if_read", if_read, exp_read);
            chk("if_read_ce", if_read_ce, exp_read);
            chk("tvalid", m_axis_tvalid, outstanding != 0);
            chk("busy", busy, (pops_rem != 0) || (outstanding != 0));
            chk("cfg_ready", cfg_ready, (pops_rem == 0) && (outstanding == 0));
            chk("done", done, exp_done);
            if (prev_hold) begin
                chk("hold_data", m_axis_tdata, prev_data);
                chk("hold_last", m_axis_tlast, prev_last);
            end
            exp_done = 1'b0;
            if (acc) begin
                exp_last = (beat_idx == cur_len - 1);
                if (acc_idx < stream_q.size()) chk("tdata", m_axis_tdata, stream_q[acc_idx]);
                else chk("tdata_extra_beat", 1, 0);
                chk("tlast", m_axis_tlast, exp_last);
                log_data.push_back(m_axis_tdata);
                log_last.push_back(m_axis_tlast);
                log_cyc.push_back(cyc);
                acc_idx++;
                beat_idx++;
                if (exp_last) exp_done = 1'b1;
                outstanding--;
            end
            if (fire) begin
                if (cfg_len == '0) begin
                    exp_done = 1'b1;
                end else begin
                    pops_rem = int'(cfg_len);
                    cur_len  = int'(cfg_len);
                    beat_idx = 0;
                end
            end
            if (if_read === 1'b1) begin
                outstanding++;
                pops_rem--;
            end
            prev_hold = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
        end
    end

    logic toggle = 1'b0;

    task automatic refresh();
        if_empty_n = (fifo_q.size() != 0);
        if_dout    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_flag && fifo_q.size() != 0) fifo_q.delete(0);
        if (toggle) m_axis_tready = ~m_axis_tready;
        refresh();
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        stream_q.push_back(w);
        refresh();
    endtask

    task automatic cfg(input int len);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_len   = LW'(len);
        while (cfg_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("cfg_accept_timeout", n < 50, 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < budget, 1);
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, p0, d0;
        refresh();
        repeat (3) tick();
        reset = 1'b0;
        mon_en = 1'b1;
        tick();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_if_read", if_read, 0);

        // Length 4, preloaded, tready high
        base = log_data.size(); p0 = pop_total; d0 = done_total;
        for (int i = 0; i < 4; i++) push(32'hA0 + i);
        m_axis_tready = 1'b1;
        cfg(4);
        wait_idle(50);
        chk("t1_beats", log_data.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", log_data[base+i], 32'hA0 + i);
            chk("t1_last", log_last[base+i], i == 3);
        end
        chk("t1_back_to_back", log_cyc[base+3] - log_cyc[base], 3);
        chk("t1_pops", pop_total - p0, 4);
        chk("t1_done", done_total - d0, 1);

        // Length 0
        base = log_data.size(); p0 = pop_total; d0 = done_total;
        cfg(0);
        chk("t2_done_pulse", done, 1);
        chk("t2_busy", busy, 0);
        tick(); tick();
        chk("t2_pops", pop_total - p0, 0);
        chk("t2_beats", log_data.size() - base, 0);
        chk("t2_done", done_total - d0, 1);

        // Length 8 with tready toggling
        base = log_data.size(); p0 = pop_total;
        for (int i = 0; i < 8; i++) push(32'hE0 + i);
        toggle = 1'b1;
        m_axis_tready = 1'b1;
        cfg(8);
        wait_idle(100);
        toggle = 1'b0;
        m_axis_tready = 1'b1;
        chk("t3_beats", log_data.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t3_data", log_data[base+i], 32'hE0 + i);
            chk("t3_last", log_last[base+i], i == 7);
        end
        chk("t3_pops", pop_total - p0, 8);

        // Length 3 from 5 words, then length 2 takes the rest
        base = log_data.size(); p0 = pop_total;
        for (int i = 0; i < 5; i++) push(32'hB0 + i);
        cfg(3);
        wait_idle(50);
        chk("t4_pops", pop_total - p0, 3);
        chk("t4_left", fifo_q.size(), 2);
        chk("t4_empty_n", if_empty_n, 1);
        cfg(2);
        wait_idle(50);
        chk("t4_beats", log_data.size() - base, 5);
        chk("t4_data3", log_data[base+3], 32'hB3);
        chk("t4_data4", log_data[base+4], 32'hB4);
        chk("t4_last3", log_last[base+3], 0);
        chk("t4_last4", log_last[base+4], 1);

        // Length 6 with a FIFO gap after word 2
        base = log_data.size(); p0 = pop_total;
        push(32'h60); push(32'h61);
        cfg(6);
        repeat (6) tick();
        chk("t5_bubble_tvalid", m_axis_tvalid, 0);
        chk("t5_bubble_busy", busy, 1);
        for (int i = 2; i < 6; i++) push(32'h60 + i);
        wait_idle(50);
        chk("t5_beats", log_data.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            chk("t5_data", log_data[base+i], 32'h60 + i);
            chk("t5_last", log_last[base+i], i == 5);
        end
        chk("t5_pops", pop_total - p0, 6);

        // Reset after 2 of 5 beats
        base = log_data.size();
        for (int i = 0; i < 5; i++) push(32'hC0 + i);
        m_axis_tready = 1'b1;
        cfg(5);
        for (int n = 0; n < 20 && log_data.size() < base + 2; n++) tick();
        m_axis_tready = 1'b0;
        chk("t6_beats_before_reset", log_data.size() - base, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_tvalid", m_axis_tvalid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cfg_ready", cfg_ready, 1);
        chk("t6_done", done, 0);
        fifo_q.delete();
        refresh();
        d0 = done_total;
        repeat (3) tick();
        chk("t6_no_done", done_total - d0, 0);
        base = log_data.size(); d0 = done_total;
        m_axis_tready = 1'b1;
        push(32'hD0);
        cfg(1);
        wait_idle(50);
        chk("t6_new_beats", log_data.size() - base, 1);
        chk("t6_new_data", log_data[base], 32'hD0);
        chk("t6_new_last", log_last[base], 1);
        chk("t6_new_done", done_total - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_axis_reader.md
Name: fifo_axis_reader

Overview:
- Read-side consumer for the team's first-word-fall-through (FWFT) stream FIFO.
- Pops words through the FIFO's empty_n/read/dout interface and presents them as an AXI4-Stream master.
- Accepts a per-packet beat count from a config handshake and asserts TLAST on the final beat.
- A 2-entry output buffer isolates m_axis_tready from if_read, so there is no combinational path from tready to the FIFO.

Parameters:
DATA_WIDTH, 32, width of FIFO words and of m_axis_tdata
LEN_WIDTH, 16, width of the packet length (beats per packet)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  packet length offered
cfg_ready  output  1  block idle, length accepted this cycle if cfg_valid
cfg_len  input  LEN_WIDTH  beats in the next packet; 0 is legal
if_empty_n  input  1  FIFO has a valid word on if_dout
if_read_ce  output  1  read clock-enable to FIFO, equal to if_read
if_read  output  1  pop the FIFO head this cycle
if_dout  input  DATA_WIDTH  FIFO head word (FWFT, valid while if_empty_n)
m_axis_tvalid  output  1  output beat valid
m_axis_tready  input  1  downstream accepts beat
m_axis_tdata  output  DATA_WIDTH  beat data
m_axis_tlast  output  1  final beat of packet
done  output  1  one-cycle pulse when packet fully delivered
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset; sampled only at the posedge of clk.
- Reset values: state IDLE, buffer count 0, pop counter 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, done 0, busy 0, if_read 0.
  - cfg_ready = (state==IDLE), so it reads 1 from the first cycle after reset.
- States: IDLE, RUN, DRAIN.
  - IDLE: on cfg_valid with cfg_len != 0, latch len, clear pop counter, go to RUN.
  - IDLE: on cfg_valid with cfg_len == 0, consume the config, pulse done in the next cycle, emit no beats, stay in IDLE.
  - RUN: if_read = if_empty_n & (count < 2). This depends only on registered state, never on m_axis_tready.
    - A pop captures if_dout in the same cycle (FWFT, zero latency) and increments the pop counter.
    - The popped beat carries tlast = (pop counter == len-1).
    - When the last word is popped, go to DRAIN.
  - DRAIN: if_read = 0. When the buffer becomes empty (the tlast beat is accepted), pulse done for 1 cycle and go to IDLE.
    - cfg_ready rises in the same cycle done is high.
- Output buffer: 2 entries (head register driving m_axis_*, plus a skid register).
  - A beat is accepted on m_axis_tvalid & m_axis_tready.
  - Count update: +1 on pop only, -1 on accept only, unchanged on both.
  - Data order is strictly FIFO. Steady state at count 1 with tready high gives 1 beat/cycle.
  - Latency from if_empty_n rising (count 0) to m_axis_tvalid is 1 cycle.
- AXIS rules:
  - Once m_axis_tvalid is asserted, tdata, tlast and tvalid hold stable until accepted.
  - tvalid does not depend on tready.
- Boundaries:
  - count == 2: no pop, even if tready is high that cycle.
  - if_empty_n low: no pop and the pop counter holds; gaps in the FIFO produce tvalid bubbles only.
  - len = 2^LEN_WIDTH-1: the counter must not wrap before tlast.
  - No if_read in IDLE or DRAIN; words belonging to the next packet stay in the FIFO.
- Reset mid-packet: all state is cleared within 1 cycle.
  - Buffered beats are discarded and tvalid drops with no tlast.
  - Words already popped are lost; the FIFO itself is reset separately by its owner.
  - No done pulse is issued.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_DRAIN), buffer depth constant (2).
- Sub-module axis_skid_buf, parameterised on DATA_WIDTH+1 (data plus last), containing the 2-entry buffer with a count output.
- Top level holds the FSM, the pop counter and the config latch.

Test Plan:
- Length 4, FIFO preloaded with 0xA0..0xA3, tready=1 -> beats A0,A1,A2,A3 on consecutive cycles; tlast only with A3; done pulses 1 cycle after the A3 accept; exactly 4 if_read pulses.
- Length 0 -> cfg accepted; no tvalid; done pulses the next cycle; no if_read.
- Length 8, tready toggling 1,0,1,0 -> all 8 beats delivered in order with no duplicates; data stable while stalled; if_read never asserted when count==2.
- Length 3, FIFO holds 5 words -> exactly 3 pops; 2 words remain (if_empty_n stays 1); second cfg of length 2 delivers the remaining words with tlast on the 2nd.
- Length 6, FIFO empty for 3 cycles between words 2 and 3 -> tvalid bubbles only; tlast on word 6; pop count is exactly 6.
- Reset asserted after 2 of 5 beats are accepted -> next cycle tvalid=0, busy=0, cfg_ready=1; no done pulse; a new length-1 packet then works normally.
